// File: rtl/fp_mul_result_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : fp_mul_result_queue                                           |
// | Description : Classifying FIFO for single-precision multiplier products,    |
// |               with sticky exception flags and a saturating NaN counter.     |
// |               Optional same-cycle bypass when empty: define FPQ_BYPASS_EN.  |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module fp_mul_result_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [2:0]                 out_class,
  input  logic                       clr_sticky,
  output logic                       sticky_nan,
  output logic                       sticky_inf,
  output logic                       sticky_zero,
  output logic [CNT_W-1:0]           nan_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [2:0] CLS_NORMAL = 3'd0;
  localparam logic [2:0] CLS_ZERO   = 3'd1;
  localparam logic [2:0] CLS_SUB    = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_NAN    = 3'd4;

  logic [31:0]      res_mem_q [DEPTH];
  logic [2:0]       cls_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             sticky_nan_q, sticky_inf_q, sticky_zero_q;
  logic             sticky_nan_d, sticky_inf_d, sticky_zero_d;
  logic [CNT_W-1:0] nan_count_q, nan_count_d;

  logic [2:0]       in_class;
  logic             fifo_valid, bypass, push, fifo_push, pop;

  always_comb begin
    in_class = CLS_NORMAL;
    if (in_result[30:23] == 8'hFF) begin
      in_class = (in_result[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (in_result[30:23] == 8'h00) begin
      in_class = (in_result[22:0] != 23'd0) ? CLS_SUB : CLS_ZERO;
    end
  end

  assign in_ready   = (level_q != LVL_W'(DEPTH));
  assign fifo_valid = (level_q != '0);

`ifdef FPQ_BYPASS_EN
  assign bypass = !fifo_valid && in_valid && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = fifo_valid || bypass;
  assign push      = in_valid && in_ready;
  // A bypassed word is consumed directly and never occupies a slot.
  assign fifo_push = push && !bypass;
  assign pop       = fifo_valid && out_ready;

  always_comb begin
    out_result = '0;
    out_class  = '0;
    if (fifo_valid) begin
      out_result = res_mem_q[rd_ptr_q];
      out_class  = cls_mem_q[rd_ptr_q];
    end else if (bypass) begin
      out_result = in_result;
      out_class  = in_class;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      res_mem_q[wr_ptr_q] <= in_result;
      cls_mem_q[wr_ptr_q] <= in_class;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({fifo_push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Clear first, then let an accepted word re-raise its flag so the push wins.
  always_comb begin
    sticky_nan_d  = clr_sticky ? 1'b0 : sticky_nan_q;
    sticky_inf_d  = clr_sticky ? 1'b0 : sticky_inf_q;
    sticky_zero_d = clr_sticky ? 1'b0 : sticky_zero_q;
    nan_count_d   = clr_sticky ? '0   : nan_count_q;
    if (push) begin
      case (in_class)
        CLS_NAN: begin
          sticky_nan_d = 1'b1;
          if (nan_count_d != {CNT_W{1'b1}}) nan_count_d = nan_count_d + CNT_W'(1);
        end
        CLS_INF:  sticky_inf_d  = 1'b1;
        CLS_ZERO: sticky_zero_d = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_nan_q  <= 1'b0;
      sticky_inf_q  <= 1'b0;
      sticky_zero_q <= 1'b0;
      nan_count_q   <= '0;
    end else begin
      sticky_nan_q  <= sticky_nan_d;
      sticky_inf_q  <= sticky_inf_d;
      sticky_zero_q <= sticky_zero_d;
      nan_count_q   <= nan_count_d;
    end
  end

  assign sticky_nan  = sticky_nan_q;
  assign sticky_inf  = sticky_inf_q;
  assign sticky_zero = sticky_zero_q;
  assign nan_count   = nan_count_q;
  assign level       = level_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_result_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_fp_mul_result_queue                                        |
// | Description : Self-checking bench: classification vectors, scoreboarded     |
// |               FIFO ordering, full/empty corners, sticky/counter, reset.     |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module tb_fp_mul_result_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int NVEC  = 12;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cls;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_result = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_result;
  logic [2:0]        out_class;
  logic              clr_sticky = 1'b0;
  logic              sticky_nan, sticky_inf, sticky_zero;
  logic [CNT_W-1:0]  nan_count;
  logic [2:0]        level;
  logic [2:0]        drv_cls = '0;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t sb[$];
  vec_t vecs[NVEC];

  fp_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_class(out_class),
    .clr_sticky(clr_sticky),
    .sticky_nan(sticky_nan), .sticky_inf(sticky_inf), .sticky_zero(sticky_zero),
    .nan_count(nan_count), .level(level)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Scoreboard: push on accepted input, pop/compare on consumed output.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("level_vs_model", 32'(level), 32'(sb.size()));
      if (in_valid && in_ready) sb.push_back('{data: in_result, cls: drv_cls});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("pop_underflow", 32'd1, 32'd0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("sb_result", out_result, e.data);
          chk("sb_class", 32'(out_class), 32'(e.cls));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [2:0] c);
    in_valid  = 1'b1;
    in_result = d;
    drv_cls   = c;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    int exp_nan;
    vecs[0]  = '{32'h44219100, 3'd0};
    vecs[1]  = '{32'h00000000, 3'd1};
    vecs[2]  = '{32'h00400000, 3'd2};
    vecs[3]  = '{32'h7F800000, 3'd3};
    vecs[4]  = '{32'h7FC00000, 3'd4};
    vecs[5]  = '{32'h80000000, 3'd1};
    vecs[6]  = '{32'hFF800000, 3'd3};
    vecs[7]  = '{32'h807FFFFF, 3'd2};
    vecs[8]  = '{32'hFFFFFFFF, 3'd4};
    vecs[9]  = '{32'h7F7FFFFF, 3'd0};
    vecs[10] = '{32'h00800000, 3'd0};
    vecs[11] = '{32'h7F800001, 3'd4};

    // Reset state
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_stickies", {29'd0, sticky_nan, sticky_inf, sticky_zero}, 32'd0);
    chk("rst_nan_count", 32'(nan_count), 32'd0);
    rst_n = 1'b1;
    step();

    // Streamed classification vectors, out_ready held high
    out_ready = 1'b1;
    exp_nan = 0;
    for (int i = 0; i <= NVEC; i++) begin
      if (i < NVEC) begin
        in_valid  = 1'b1;
        in_result = vecs[i].data;
        drv_cls   = vecs[i].cls;
        if (vecs[i].cls == 3'd4) exp_nan++;
      end else begin
        in_valid = 1'b0;
      end
`ifndef FPQ_BYPASS_EN
      if (i > 0) begin
        @(negedge clk);
        chk("lat1_out_valid", 32'(out_valid), 32'd1);
        chk("lat1_out_class", 32'(out_class), 32'(vecs[i-1].cls));
      end
`endif
      step();
    end
    step();
    chk("stream_sticky_zero", 32'(sticky_zero), 32'd1);
    chk("stream_sticky_inf", 32'(sticky_inf), 32'd1);
    chk("stream_sticky_nan", 32'(sticky_nan), 32'd1);
    chk("stream_nan_count", 32'(nan_count), 32'(exp_nan));

    // Fill to full, hold off a fifth word, then push+pop on full
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word(32'h3F800000 + 32'(i), 3'd0);
    chk("full_level", 32'(level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_result = 32'h3F800004; drv_cls = 3'd0;
    step();
    @(negedge clk);
    chk("held_level", 32'(level), 32'd4);
    chk("held_out_result", out_result, 32'h3F800000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("fullpp_level", 32'(level), 32'd3);
    chk("fullpp_in_ready", 32'(in_ready), 32'd1);
    repeat (4) step();
    chk("drain_level", 32'(level), 32'd0);

    // Sticky clear vs push, saturation
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h7FC00000, 3'd4);
    chk("nan_count_5", 32'(nan_count), 32'd5);
    clr_sticky = 1'b1;
    push_word(32'hFFFFFFFF, 3'd4);
    clr_sticky = 1'b0;
    chk("clrpush_sticky_nan", 32'(sticky_nan), 32'd1);
    chk("clrpush_nan_count", 32'(nan_count), 32'd1);
    chk("clrpush_sticky_inf", 32'(sticky_inf), 32'd0);
    chk("clrpush_sticky_zero", 32'(sticky_zero), 32'd0);
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
    chk("clr_stickies", {29'd0, sticky_nan, sticky_inf, sticky_zero}, 32'd0);
    chk("clr_nan_count", 32'(nan_count), 32'd0);
    for (int i = 0; i < 9; i++) push_word(32'hFFC00001, 3'd4);
    chk("nan_count_sat", 32'(nan_count), 32'd7);
    clr_sticky = 1'b1;
    push_word(32'h80000000, 3'd1);
    clr_sticky = 1'b0;
    chk("clrzero_sticky_zero", 32'(sticky_zero), 32'd1);
    chk("clrzero_nan_count", 32'(nan_count), 32'd0);
    step();

    // Asynchronous reset in mid-cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h40000000 + 32'(i), 3'd0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    push_word(32'h80000000, 3'd1);
`ifndef FPQ_BYPASS_EN
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_out_class", 32'(out_class), 32'd1);
`endif
    step();

`ifdef FPQ_BYPASS_EN
    in_valid = 1'b1; in_result = 32'h7F800000; drv_cls = 3'd3;
    #1;
    chk("byp_out_valid", 32'(out_valid), 32'd1);
    chk("byp_out_class", 32'(out_class), 32'd3);
    chk("byp_level", 32'(level), 32'd0);
    step();
    in_valid = 1'b0;
    chk("byp_sticky_inf", 32'(sticky_inf), 32'd1);
    step();
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
